// File: rtl/wire_cmd_sequencer_pkg.sv
// rtl/wire_cmd_sequencer_pkg.sv - shared opcodes, states, field positions for wire_cmd_sequencer
// Contents: opcode constants, FSM state encoding, status-word bit positions,
// command-word field positions and slice helpers.
package wire_cmd_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_SETLED = 4'd4;
  localparam logic [3:0] OP_CLEAR  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_MUL    = 2'd2,
    ST_COMMIT = 2'd3
  } seq_state_t;

  // status_wire layout
  localparam int ST_TAG_LSB  = 0;
  localparam int ST_BUSY_BIT = 8;
  localparam int ST_ERR_BIT  = 9;
  localparam int ST_OVR_BIT  = 10;
  localparam int ST_OP_LSB   = 12;
  localparam int ST_CNT_LSB  = 16;

  // cmd_wire layout
  localparam int CMD_TAG_LSB = 0;
  localparam int CMD_OP_LSB  = 8;
  localparam int CMD_LED_LSB = 16;

  function automatic logic [7:0] cmd_tag(input logic [31:0] c);
    return c[CMD_TAG_LSB +: 8];
  endfunction

  function automatic logic [3:0] cmd_op(input logic [31:0] c);
    return c[CMD_OP_LSB +: 4];
  endfunction

  function automatic logic [7:0] cmd_led(input logic [31:0] c);
    return c[CMD_LED_LSB +: 8];
  endfunction

endpackage

// File: rtl/wire_cmd_sequencer_if.sv
// rtl/wire_cmd_sequencer_if.sv - host wire bundle between okHost endpoints and the sequencer
// master: host side (drives cmd/opa/opb WireIns, reads result/status WireOuts, led_val)
// slave:  sequencer side
interface wire_cmd_sequencer_if;
  logic [31:0] cmd_wire;
  logic [31:0] opa_wire;
  logic [31:0] opb_wire;
  logic [31:0] result_wire;
  logic [31:0] status_wire;
  logic [7:0]  led_val;

  modport master (
    output cmd_wire, opa_wire, opb_wire,
    input  result_wire, status_wire, led_val
  );

  modport slave (
    input  cmd_wire, opa_wire, opb_wire,
    output result_wire, status_wire, led_val
  );
endinterface

// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - 32-cycle radix-2 shift-add unsigned multiplier (low 32 bits)
// Ports: ti_clk, reset (async, active-high), start (loads a/b), a, b,
//        done (high during the cycle whose edge performs step 31), p (product).
module seq_shift_add_mul (
  input  logic        ti_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] p
);

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] p_q;
  logic [4:0]  step_q;
  logic        run_q;

  // Combinational so the sequencer can leave its MUL state on the same edge
  // that retires the final step; p is valid the cycle after.
  assign done = run_q && (step_q == 5'd31);
  assign p    = p_q;

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      p_q    <= '0;
      step_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      if (b_q[0]) begin
        p_q <= p_q + a_q;
      end
      a_q    <= a_q << 1;
      b_q    <= b_q >> 1;
      step_q <= step_q + 5'd1;
      if (step_q == 5'd31) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wire_cmd_sequencer.sv
// rtl/wire_cmd_sequencer.sv - tag-triggered host command sequencer (ADD/SUB/MUL/SETLED/CLEAR)
// Ports: ti_clk, reset (async, active-high), bus (wire_cmd_sequencer_if.slave:
//        cmd/opa/opb WireIns in, result/status WireOuts and led_val out).
// Params: MUL_EN (0 makes opcode 3 illegal), LED_RESET (led_val reset value).
module wire_cmd_sequencer
  import wire_cmd_pkg::*;
#(
  parameter bit         MUL_EN    = 1'b1,
  parameter logic [7:0] LED_RESET = 8'h00
) (
  input  logic               ti_clk,
  input  logic               reset,
  wire_cmd_sequencer_if.slave bus
);

  seq_state_t  state_q, state_nxt;
  logic [7:0]  last_tag_q, prev_tag_q;
  logic [7:0]  sh_tag_q, sh_led_q;
  logic [3:0]  sh_op_q;
  logic [31:0] sh_opa_q, sh_opb_q;
  logic [31:0] acc_q, result_q;
  logic [7:0]  led_q, done_tag_q;
  logic [3:0]  done_op_q;
  logic        err_q, ovr_q;
  logic [15:0] cnt_q;

  logic [7:0]  tag_in;
  logic [3:0]  op_in;
  logic        accept, mul_in, mul_done, sh_legal;
  logic [31:0] mul_p;

  assign tag_in = cmd_tag(bus.cmd_wire);
  assign op_in  = cmd_op(bus.cmd_wire);
  assign accept = (state_q == ST_IDLE) && (tag_in != last_tag_q);
  assign mul_in = MUL_EN && (op_in == OP_MUL);
  assign sh_legal = (sh_op_q <= OP_CLEAR) && !((sh_op_q == OP_MUL) && !MUL_EN);

  // Operands go straight from the WireIns at the accept edge, same as the shadows.
  seq_shift_add_mul u_mul (
    .ti_clk (ti_clk),
    .reset  (reset),
    .start  (accept && mul_in),
    .a      (bus.opa_wire),
    .b      (bus.opb_wire),
    .done   (mul_done),
    .p      (mul_p)
  );

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_nxt = mul_in ? ST_MUL : ST_EXEC;
      ST_EXEC:   state_nxt = ST_COMMIT;
      ST_MUL:    if (mul_done) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      last_tag_q <= '0;
      prev_tag_q <= '0;
      sh_tag_q   <= '0;
      sh_led_q   <= '0;
      sh_op_q    <= '0;
      sh_opa_q   <= '0;
      sh_opb_q   <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      led_q      <= LED_RESET;
      done_tag_q <= '0;
      done_op_q  <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      prev_tag_q <= tag_in;
      // Any tag movement while not idle means the host outran us; only the
      // tag present when we return to IDLE is executed.
      if ((state_q != ST_IDLE) && (tag_in != prev_tag_q)) begin
        ovr_q <= 1'b1;
      end
      if (accept) begin
        last_tag_q <= tag_in;
        sh_tag_q   <= tag_in;
        sh_op_q    <= op_in;
        sh_led_q   <= cmd_led(bus.cmd_wire);
        sh_opa_q   <= bus.opa_wire;
        sh_opb_q   <= bus.opb_wire;
      end
      if (state_q == ST_EXEC) begin
        if (sh_op_q == OP_ADD)      acc_q <= sh_opa_q + sh_opb_q;
        else if (sh_op_q == OP_SUB) acc_q <= sh_opa_q - sh_opb_q;
      end
      if (state_q == ST_COMMIT) begin
        done_tag_q <= sh_tag_q;
        done_op_q  <= sh_op_q;
        err_q      <= !sh_legal;
        cnt_q      <= cnt_q + 16'd1;
        case (sh_op_q)
          OP_ADD, OP_SUB: result_q <= acc_q;
          OP_MUL:         if (MUL_EN) result_q <= mul_p;
          OP_SETLED:      led_q <= sh_led_q;
          OP_CLEAR: begin
            result_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.status_wire = '0;
    bus.status_wire[ST_TAG_LSB +: 8]  = done_tag_q;
    bus.status_wire[ST_BUSY_BIT]      = (state_q != ST_IDLE);
    bus.status_wire[ST_ERR_BIT]       = err_q;
    bus.status_wire[ST_OVR_BIT]       = ovr_q;
    bus.status_wire[ST_OP_LSB +: 4]   = done_op_q;
    bus.status_wire[ST_CNT_LSB +: 16] = cnt_q;
  end

  assign bus.result_wire = result_q;
  assign bus.led_val     = led_q;

endmodule

// File: doc/wire_cmd_sequencer.md
Name: wire_cmd_sequencer

Overview:
- Host-command sequencer between the okHost wire endpoints and a small arithmetic/LED datapath, all in the `ti_clk` domain.
- The host writes operands and a command word through three WireIns, then bumps an 8-bit tag to issue the command.
- The block accepts the command, executes ADD/SUB/MUL/SETLED/CLEAR, and publishes the result and a status word on two WireOuts.
- The tag is echoed in status so the host can poll for completion.

Parameters:
- MUL_EN, 1: 1 = opcode MUL implemented; 0 = MUL treated as illegal opcode.
- LED_RESET, 8'h00: reset value of `led_val`.

Ports:
- ti_clk  in  1  okHost interface clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_wire  in  32  [7:0] tag, [11:8] opcode, [15:12] reserved, [23:16] LED value, [31:24] reserved.
- opa_wire  in  32  operand A.
- opb_wire  in  32  operand B.
- result_wire  out  32  last committed result.
- status_wire  out  32  [7:0] last completed tag, [8] busy, [9] error, [10] overrun, [11] reserved 0, [15:12] last opcode, [31:16] completed-command count.
- led_val  out  8  LED pattern, active-high. Top level converts it to open-drain.

Behaviour:
- Reset (asynchronous, active-high), all registers cleared:
  - `result_wire` = 0, `status_wire` = 0, `led_val` = LED_RESET.
  - State = IDLE; `last_tag` = 0; `prev_tag` = 0; shadow registers = 0.
  - Reset mid-operation aborts the operation; no commit occurs.
  - After reset release, a nonzero `cmd_wire` tag re-issues that command.
- Opcodes (unsigned, mod 2^32): 0 NOP, 1 ADD A+B, 2 SUB A-B, 3 MUL low 32 bits of A*B, 4 SETLED, 5 CLEAR. Opcodes 6-15 are illegal.
- States: IDLE, EXEC, MUL, COMMIT.
- IDLE:
  - If `cmd_wire[7:0]` != `last_tag` at edge k: capture cmd, opa and opb into shadow registers; `last_tag` <= tag; busy <= 1.
  - Go to MUL if opcode == 3 and MUL_EN = 1, else go to EXEC.
  - If the tag equals `last_tag`, do nothing.
- EXEC (edge k+1): compute into accumulator; go to COMMIT.
- MUL (edges k+1..k+32):
  - Radix-2 shift-add, exactly 32 cycles, driven by a 5-bit step counter.
  - Go to COMMIT after step 31.
- COMMIT (edge k+2 for single-cycle ops, edge k+33 for MUL):
  - Update `result_wire`: ADD/SUB/MUL take the accumulator; CLEAR sets 0; NOP/SETLED/illegal leave it unchanged.
  - SETLED: `led_val` <= `cmd[23:16]`.
  - CLEAR: count <= 0, overrun <= 0, `led_val` unchanged.
  - status[7:0] <= tag; status[15:12] <= opcode.
  - error <= (opcode illegal).
  - Count <= count + 1, wrapping at 16 bits; CLEAR sets 0 instead of incrementing.
  - busy <= 0; next state IDLE.
- Operands are sampled only at the accept edge. Changes to `opa_wire`/`opb_wire` during execution do not affect the result.
- Overrun:
  - `prev_tag` registers `cmd_wire[7:0]` every cycle.
  - If state != IDLE and `cmd_wire[7:0]` != `prev_tag`, overrun <= 1 (sticky until CLEAR or reset).
  - After COMMIT, IDLE accepts the tag present at that time. Intermediate tags are dropped.
- Back-to-back: a new tag present at the COMMIT edge is accepted on the following IDLE edge. Minimum command period is 3 cycles (single-cycle ops) or 34 cycles (MUL).
- A tag write in the same cycle as COMMIT is not an overrun only if it occurs in IDLE. COMMIT != IDLE, so it flags overrun.

Decomposition:
- Package `wire_cmd_pkg`:
  - Opcode constants: OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_SETLED, OP_CLEAR.
  - State encoding.
  - Status bit-position constants.
  - Command field slices.
- Sub-module `seq_shift_add_mul`:
  - Inputs: start, a[31:0], b[31:0]. Outputs: done (1-cycle pulse), p[31:0].
  - 32-cycle iterative unsigned multiplier.
  - Asynchronous active-high reset on `ti_clk`.

Test Plan:
- ADD: opa = 5, opb = 7, cmd = 32'h0000_0101 → after 2 edges: result = 12; status = 32'h0001_1001; busy high for exactly 2 cycles.
- SUB wrap: opa = 0, opb = 1, tag 2, op 2 → result = 32'hFFFF_FFFF; count = 2; error = 0.
- MUL: opa = 32'h0001_0003, opb = 32'h0000_0010, tag 3, op 3 → result = 32'h0010_0030 exactly 33 edges after accept. Repeat with MUL_EN = 0 → error = 1, result unchanged, count increments.
- Overrun: during a MUL, change tag 4 → 5 → 6 → overrun = 1; after commit, tag 6 executes and tag 5 never appears in status. CLEAR with tag 7 → overrun = 0, count = 0, result = 0.
- SETLED / illegal: cmd = 32'h00A5_0408 → `led_val` = 8'hA5. Then opcode 9, tag 9 → error = 1, `led_val` stays 8'hA5, status[7:0] = 8'h09.
- Reset mid-MUL: assert reset at step 10 → all outputs zero and `led_val` = LED_RESET immediately. Release with tag 3 held → MUL re-executes and commits the correct product.
